// File: rtl/signed_symbol_mapper_stream_if.sv
// rtl/signed_symbol_mapper_stream_if.sv - coefficient-in / symbol-out stream handshake bundle
interface signed_symbol_mapper_stream_if #(
  parameter int DATA_W = 20
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_sym;
  logic              m_last;

  // Environment side: produces coefficients, consumes symbols
  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_sym, m_last
  );

  // Mapper side: consumes coefficients, produces symbols
  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_sym, m_last
  );
endinterface

// File: rtl/signed_symbol_mapper_stream.sv
// rtl/signed_symbol_mapper_stream.sv - streaming signed-to-symbol mapper with per-block saturating sum
module signed_symbol_mapper_stream #(
  parameter int DATA_W    = 20,
  parameter int SUM_W     = 24,
  parameter int BLOCK_LEN = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  signed_symbol_mapper_stream_if.slave bus,
  output logic                sum_valid,
  output logic [SUM_W-1:0]    sum_data,
  output logic                sum_sat
);
  localparam int CNT_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_LEN - 1);
  localparam int PAD_W = SUM_W + 1 - DATA_W;

  logic [CNT_W-1:0]  idx;
  logic [SUM_W-1:0]  acc;
  logic              sat;

  logic              accept;
  logic              at_last;
  logic [DATA_W-1:0] sym;
  logic [SUM_W:0]    acc_wide;
  logic [SUM_W-1:0]  acc_clamped;
  logic              sat_next;

  // One output register: room exists when it is empty or draining this cycle; flush blocks input
  assign bus.s_ready = (!bus.m_valid || bus.m_ready) && !clear;
  assign accept      = bus.s_valid && bus.s_ready;
  assign at_last     = (idx == LAST_IDX);

  // Zig-zag map: 2v for v>=0, 2|v|-1 for v<0. The shift-and-xor form equals the
  // DATA_W+1-bit arithmetic result and always fits back in DATA_W bits.
  always_comb begin
    sym         = (bus.s_data << 1) ^ {DATA_W{bus.s_data[DATA_W-1]}};
    acc_wide    = {1'b0, acc} + {{PAD_W{1'b0}}, sym};
    acc_clamped = acc_wide[SUM_W] ? {SUM_W{1'b1}} : acc_wide[SUM_W-1:0];
    sat_next    = sat | acc_wide[SUM_W];
  end

  // Output register, block index, running sum and per-block sum report
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.m_valid <= 1'b0;
      bus.m_sym   <= '0;
      bus.m_last  <= 1'b0;
      idx         <= '0;
      acc         <= '0;
      sat         <= 1'b0;
      sum_valid   <= 1'b0;
      sum_data    <= '0;
      sum_sat     <= 1'b0;
    end else if (clear) begin
      // Flush the in-flight symbol and partial block; the last reported sum stays visible
      bus.m_valid <= 1'b0;
      bus.m_last  <= 1'b0;
      idx         <= '0;
      acc         <= '0;
      sat         <= 1'b0;
      sum_valid   <= 1'b0;
    end else begin
      sum_valid <= 1'b0;
      if (accept) begin
        bus.m_valid <= 1'b1;
        bus.m_sym   <= sym;
        bus.m_last  <= at_last;
        if (at_last) begin
          idx       <= '0;
          acc       <= '0;
          sat       <= 1'b0;
          sum_valid <= 1'b1;
          sum_data  <= acc_clamped;
          sum_sat   <= sat_next;
        end else begin
          idx <= idx + 1'b1;
          acc <= acc_clamped;
          sat <= sat_next;
        end
      end else if (bus.m_ready) begin
        bus.m_valid <= 1'b0;
        bus.m_last  <= 1'b0;
      end
    end
  end
endmodule
